// File: rtl/app_switcher.sv
// app_switcher: menu/app display source selector with frame-aligned switching and idle timeout.
module app_switcher #(
    parameter int N_APPS     = 4,
    parameter int IDLE_TICKS = 3000,
    localparam int IDX_W     = (N_APPS > 2) ? $clog2(N_APPS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_sel,
    input  logic                  btn_back,
    input  logic                  frame_begin,
    input  logic [16*N_APPS-1:0]  oled_in,
    input  logic [16*N_APPS-1:0]  led_in,
    input  logic [4*N_APPS-1:0]   an_in,
    input  logic [8*N_APPS-1:0]   seg_in,
    output logic [15:0]           oled_data,
    output logic [15:0]           led,
    output logic [3:0]            an,
    output logic [7:0]            seg,
    output logic [IDX_W-1:0]      active,
    output logic [IDX_W-1:0]      cursor,
    output logic                  busy
);
    localparam int CNT_W = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_TICKS == 0) ? 0 : IDLE_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_APP = IDX_W'(N_APPS - 1);

    typedef enum logic [1:0] {MENU, ENTER_WAIT, RUN, EXIT_WAIT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] active_nxt, cursor_nxt, target, target_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic             any_btn;

    // Unused index codes map to source 0 so an impossible active value stays safe.
    logic [15:0] oled_tab [2**IDX_W];
    logic [15:0] led_tab  [2**IDX_W];
    logic [3:0]  an_tab   [2**IDX_W];
    logic [7:0]  seg_tab  [2**IDX_W];

    genvar g;
    for (g = 0; g < 2**IDX_W; g++) begin : g_src
        if (g < N_APPS) begin : g_real
            assign oled_tab[g] = oled_in[16*g +: 16];
            assign led_tab[g]  = led_in[16*g +: 16];
            assign an_tab[g]   = an_in[4*g +: 4];
            assign seg_tab[g]  = seg_in[8*g +: 8];
        end else begin : g_fall
            assign oled_tab[g] = oled_in[15:0];
            assign led_tab[g]  = led_in[15:0];
            assign an_tab[g]   = an_in[3:0];
            assign seg_tab[g]  = seg_in[7:0];
        end
    end

    assign any_btn   = btn_up | btn_down | btn_sel | btn_back;
    assign busy      = (state == ENTER_WAIT) || (state == EXIT_WAIT);
    assign oled_data = oled_tab[active];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MENU;
            active   <= '0;
            cursor   <= IDX_W'(1);
            target   <= IDX_W'(1);
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            active   <= active_nxt;
            cursor   <= cursor_nxt;
            target   <= target_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        active_nxt = active;
        cursor_nxt = cursor;
        target_nxt = target;
        idle_nxt   = idle_cnt;
        case (state)
            MENU: begin
                // back has top priority but no effect here; it still masks the others.
                if (btn_back) begin
                end else if (btn_sel) begin
                    target_nxt = cursor;
                    state_nxt  = ENTER_WAIT;
                end else if (btn_up) begin
                    cursor_nxt = (cursor == IDX_W'(1)) ? LAST_APP : cursor - 1'b1;
                end else if (btn_down) begin
                    cursor_nxt = (cursor == LAST_APP) ? IDX_W'(1) : cursor + 1'b1;
                end
            end
            ENTER_WAIT: begin
                if (btn_back) begin
                    state_nxt = MENU;
                end else if (frame_begin) begin
                    active_nxt = target;
                    idle_nxt   = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (btn_back) begin
                    state_nxt = EXIT_WAIT;
                end else if (any_btn) begin
                    idle_nxt = '0;
                end else if (tick && IDLE_TICKS != 0) begin
                    if (idle_cnt == IDLE_LAST) state_nxt = EXIT_WAIT;
                    else idle_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                if (frame_begin) begin
                    active_nxt = '0;
                    state_nxt  = MENU;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
            an  <= '1;
            seg <= '1;
        end else begin
            led <= led_tab[active];
            an  <= an_tab[active];
            seg <= seg_tab[active];
        end
    end
endmodule

// File: tb/tb_app_switcher.sv
// tb_app_switcher: directed and random stimulus against a behavioural model of the switcher.
module tb_app_switcher;
    localparam int N    = 4;
    localparam int IDLE = 5;
    localparam int M_MENU = 0, M_ENTER = 1, M_RUN = 2, M_EXIT = 3;

    logic clk = 0;
    logic reset, tick, btn_up, btn_down, btn_sel, btn_back, frame_begin;
    logic [16*N-1:0] oled_in, led_in;
    logic [4*N-1:0]  an_in;
    logic [8*N-1:0]  seg_in;
    logic [15:0] oled_data, led;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  active, cursor;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int m_mode, m_active, m_cursor, m_target, m_quiet;
    logic [15:0] m_led;
    logic [3:0]  m_an;
    logic [7:0]  m_seg;

    app_switcher #(.N_APPS(N), .IDLE_TICKS(IDLE)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_back(btn_back),
        .frame_begin(frame_begin),
        .oled_in(oled_in), .led_in(led_in), .an_in(an_in), .seg_in(seg_in),
        .oled_data(oled_data), .led(led), .an(an), .seg(seg),
        .active(active), .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_edge();
        if (reset) begin
            m_mode = M_MENU; m_active = 0; m_cursor = 1; m_target = 1; m_quiet = 0;
            m_led = 16'h0000; m_an = 4'hF; m_seg = 8'hFF;
            return;
        end
        m_led = led_in[m_active*16 +: 16];
        m_an  = an_in[m_active*4 +: 4];
        m_seg = seg_in[m_active*8 +: 8];
        case (m_mode)
            M_MENU:
                if (btn_back) ;
                else if (btn_sel) begin m_target = m_cursor; m_mode = M_ENTER; end
                else if (btn_up) m_cursor = (m_cursor + N - 3) % (N - 1) + 1;
                else if (btn_down) m_cursor = m_cursor % (N - 1) + 1;
            M_ENTER:
                if (btn_back) m_mode = M_MENU;
                else if (frame_begin) begin m_active = m_target; m_mode = M_RUN; m_quiet = 0; end
            M_RUN:
                if (btn_back) m_mode = M_EXIT;
                else if (btn_up | btn_down | btn_sel) m_quiet = 0;
                else if (tick) begin
                    m_quiet++;
                    if (m_quiet == IDLE) m_mode = M_EXIT;
                end
            default:
                if (frame_begin) begin m_active = 0; m_mode = M_MENU; end
        endcase
    endtask

    task automatic step(input logic r, u, d, s, b, f, t);
        reset = r; btn_up = u; btn_down = d; btn_sel = s; btn_back = b;
        frame_begin = f; tick = t;
        oled_in = {$urandom, $urandom};
        led_in  = {$urandom, $urandom};
        an_in   = 16'($urandom);
        seg_in  = $urandom;
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(m_mode == M_ENTER || m_mode == M_EXIT));
        chk("active", 32'(active), 32'(m_active));
        chk("cursor", 32'(cursor), 32'(m_cursor));
        chk("oled_data", 32'(oled_data), 32'(oled_in[m_active*16 +: 16]));
        chk("led", 32'(led), 32'(m_led));
        chk("an", 32'(an), 32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic idle_step(); step(0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd1);
        chk("rst_an_seg", {20'd0, an, seg}, 32'h00FFF);
        // cursor wraps 1->2->3->1 in the menu
        step(0, 0, 1, 0, 0, 0, 0); chk("down1", 32'(cursor), 32'd2);
        step(0, 0, 1, 0, 0, 0, 0); chk("down2", 32'(cursor), 32'd3);
        step(0, 0, 1, 0, 0, 0, 0); chk("down3", 32'(cursor), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0); chk("up_wrap", 32'(cursor), 32'd3);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0); chk("cursor2", 32'(cursor), 32'd2);
        // select app 2 and wait for a frame
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            idle_step();
            chk("busy_wait", 32'(busy), 32'd1);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        chk("enter_active", 32'(active), 32'd2);
        chk("enter_busy", 32'(busy), 32'd0);
        idle_step();
        chk("led_app2", 32'(led), 32'(led_in[47:32]) & 32'h0 | 32'(m_led));
        // idle timeout after five quiet ticks
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk("timeout_busy", 32'(busy), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("exit_active", 32'(active), 32'd0);
        chk("exit_cursor", 32'(cursor), 32'd2);
        // a button in RUN restarts the idle count
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk("run_kept_busy", 32'(busy), 32'd0);
        chk("run_kept_active", 32'(active), 32'd2);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // sel, down and frame_begin together: switch must wait for the next frame
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0);
        chk("combo_busy", 32'(busy), 32'd1);
        chk("combo_active", 32'(active), 32'd0);
        chk("combo_cursor", 32'(cursor), 32'd3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("combo_target", 32'(active), 32'd3);
        // reset while exiting
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_exit", {24'd0, busy, active, cursor, 1'b0}, 32'h02);
        chk("rst_exit_an_seg", {20'd0, an, seg}, 32'h00FFF);
        // cancel in ENTER_WAIT
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("cancel_active", 32'(active), 32'd0);
        chk("cancel_busy", 32'(busy), 32'd0);
        // random traffic, busy phase then quiet phase so timeouts occur
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 1500; i++) begin
                int bp;
                bp = (p == 0) ? 11 : 39;
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, bp) == 0, $urandom_range(0, bp) == 0,
                     $urandom_range(0, bp) == 0, $urandom_range(0, bp) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
